// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Round-robin arbiter for the single integer register file write
//               port. At most one producer is granted per cycle. The granted
//               write is registered and presented to the register file one
//               cycle later. Writes to x0 are handshaked but not performed.
//               Optional macro RF_WB_FWD_EN adds two read-address compare
//               ports that flag a read colliding with the write in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REQ    = 3
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic                          i_hold,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_rf_write_en,
  output logic [ADDR_WIDTH-1:0]         o_rf_addr,
  output logic [DATA_WIDTH-1:0]         o_rf_write_data,
  output logic [15:0]                   o_wr_count
`ifdef RF_WB_FWD_EN
  ,
  input  logic [ADDR_WIDTH-1:0]         i_rd_addr_1,
  input  logic [ADDR_WIDTH-1:0]         i_rd_addr_2,
  output logic                          o_fwd_hit_1,
  output logic                          o_fwd_hit_2
`endif
);

  // NUM_REQ is at least 2, so the pointer is always at least one bit wide.
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [ADDR_WIDTH-1:0] req_addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] next_ptr;
  logic [PTR_W:0]   cand;
  logic             grant_any;

  // Split the flattened request buses into per-requester fields.
  genvar k;
  for (k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_addr_arr[k] = i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign req_data_arr[k] = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan from rr_ptr upward (wrapping) and grant the first valid requester.
  // Ready is derived from valid, hold and the pointer only.
  always_comb begin
    o_req_ready = '0;
    grant_idx   = '0;
    grant_any   = 1'b0;
    cand        = '0;
    if (!i_hold) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
        if (cand >= (PTR_W+1)'(NUM_REQ)) begin
          cand = cand - (PTR_W+1)'(NUM_REQ);
        end
        if (!grant_any && i_req_valid[cand[PTR_W-1:0]]) begin
          grant_any = 1'b1;
          grant_idx = cand[PTR_W-1:0];
        end
      end
      if (grant_any) begin
        o_req_ready[grant_idx] = 1'b1;
      end
    end
  end

  // Pointer moves to the requester just after the one granted.
  always_comb begin
    next_ptr = '0;
    if (grant_idx != PTR_W'(NUM_REQ - 1)) begin
      next_ptr = grant_idx + 1'b1;
    end
  end

  // Output register: capture the granted write; x0 writes keep wen low.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      o_rf_write_en   <= 1'b0;
      o_rf_addr       <= '0;
      o_rf_write_data <= '0;
      rr_ptr          <= '0;
    end else if (grant_any) begin
      o_rf_write_en   <= (req_addr_arr[grant_idx] != '0);
      o_rf_addr       <= req_addr_arr[grant_idx];
      o_rf_write_data <= req_data_arr[grant_idx];
      rr_ptr          <= next_ptr;
    end else begin
      o_rf_write_en   <= 1'b0;
    end
  end

  // Count every cycle in which a real write is presented; wraps naturally.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      o_wr_count <= '0;
    end else if (o_rf_write_en) begin
      o_wr_count <= o_wr_count + 16'd1;
    end
  end

`ifdef RF_WB_FWD_EN
  // Read port 1 collides with the write in flight (x0 never forwards).
  always_comb begin
    o_fwd_hit_1 = o_rf_write_en && (i_rd_addr_1 == o_rf_addr) && (i_rd_addr_1 != '0);
  end

  // Read port 2 collides with the write in flight (x0 never forwards).
  always_comb begin
    o_fwd_hit_2 = o_rf_write_en && (i_rd_addr_2 == o_rf_addr) && (i_rd_addr_2 != '0);
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed self-checking bench for regfile_wb_arbiter
//               (default 3 requesters, 64-bit data, 5-bit addresses).
//               Optional macro RF_WB_FWD_EN enables the forwarding steps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NR = 3;

  logic            clk;
  logic            arst;
  logic            hold;
  logic [NR-1:0]   req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            rf_we;
  logic [AW-1:0]   rf_addr;
  logic [DW-1:0]   rf_data;
  logic [15:0]     wr_count;
`ifdef RF_WB_FWD_EN
  logic [AW-1:0]   rd_addr_1;
  logic [AW-1:0]   rd_addr_2;
  logic            fwd_hit_1;
  logic            fwd_hit_2;
`endif

  int vectors;
  int miscompares;

  // Register file model written by the DUT write port.
  logic [DW-1:0] rf_model [32];

  regfile_wb_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_REQ   (NR)
  ) dut (
    .clk            (clk),
    .arst           (arst),
    .i_hold         (hold),
    .i_req_valid    (req_valid),
    .i_req_addr     (req_addr),
    .i_req_data     (req_data),
    .o_req_ready    (req_ready),
    .o_rf_write_en  (rf_we),
    .o_rf_addr      (rf_addr),
    .o_rf_write_data(rf_data),
    .o_wr_count     (wr_count)
`ifdef RF_WB_FWD_EN
    ,
    .i_rd_addr_1    (rd_addr_1),
    .i_rd_addr_2    (rd_addr_2),
    .o_fwd_hit_1    (fwd_hit_1),
    .o_fwd_hit_2    (fwd_hit_2)
`endif
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file capture at the edge closing each write cycle.
  always @(posedge clk) begin
    if (rf_we) rf_model[rf_addr] <= rf_data;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[k]         = v;
    req_addr[k*AW +: AW] = a;
    req_data[k*DW +: DW] = d;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    arst        = 1'b1;
    hold        = 1'b0;
    req_valid   = '0;
    req_addr    = '0;
    req_data    = '0;
`ifdef RF_WB_FWD_EN
    rd_addr_1   = '0;
    rd_addr_2   = '0;
`endif
    for (int i = 0; i < 32; i++) rf_model[i] = '0;

    // ---- reset values ----
    #3;
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_wen",   64'(rf_we),     64'h0);
    chk("rst_addr",  64'(rf_addr),   64'h0);
    chk("rst_data",  rf_data,        64'h0);
    chk("rst_count", 64'(wr_count),  64'h0);
    tick();
    arst = 1'b0;

    // ---- first write after reset: req0 -> x5 = 0xA5 ----
    set_req(0, 1'b1, 5'd5, 64'hA5);
    #1;
    chk("w1_ready", 64'(req_ready), 64'b001);
    tick();
    set_req(0, 1'b0, 5'd0, 64'h0);
    chk("w1_wen",   64'(rf_we),    64'h1);
    chk("w1_addr",  64'(rf_addr),  64'd5);
    chk("w1_data",  rf_data,       64'hA5);
    chk("w1_cnt0",  64'(wr_count), 64'd0);
    tick();
    chk("w1_wen_off", 64'(rf_we),    64'h0);
    chk("w1_cnt1",    64'(wr_count), 64'd1);

    // ---- reset in the middle of a presented write (rr_ptr is 1) ----
    set_req(1, 1'b1, 5'd3, 64'h33);
    #1;
    chk("mr_ready", 64'(req_ready), 64'b010);
    tick();
    set_req(1, 1'b0, 5'd0, 64'h0);
    chk("mr_wen_pre", 64'(rf_we), 64'h1);
    #1;
    arst = 1'b1;
    #1;
    chk("mr_wen",   64'(rf_we),     64'h0);
    chk("mr_addr",  64'(rf_addr),   64'h0);
    chk("mr_data",  rf_data,        64'h0);
    chk("mr_count", 64'(wr_count),  64'h0);
    chk("mr_ready0", 64'(req_ready), 64'h0);
    #1;
    arst = 1'b0;

    // ---- round robin: all valid, pointer back at 0 ----
    set_req(0, 1'b1, 5'd1, 64'h100);
    set_req(1, 1'b1, 5'd2, 64'h200);
    set_req(2, 1'b1, 5'd3, 64'h300);
    #1;
    for (int i = 0; i < 6; i++) begin
      logic [NR-1:0] exp_rdy;
      exp_rdy = '0;
      exp_rdy[i % 3] = 1'b1;
      chk($sformatf("rr_ready%0d", i), 64'(req_ready), 64'(exp_rdy));
      tick();
      chk($sformatf("rr_wen%0d", i),  64'(rf_we),   64'h1);
      chk($sformatf("rr_addr%0d", i), 64'(rf_addr), 64'((i % 3) + 1));
      chk($sformatf("rr_data%0d", i), rf_data,      64'(((i % 3) + 1) * 256));
    end
    req_valid = '0;
    tick();
    chk("rr_wen_off", 64'(rf_we),    64'h0);
    chk("rr_count",   64'(wr_count), 64'd6);

    // ---- x0 drop (pointer at 0, only req1 valid) ----
    set_req(1, 1'b1, 5'd0, 64'hFF);
    #1;
    chk("x0_ready", 64'(req_ready), 64'b010);
    tick();
    set_req(1, 1'b0, 5'd0, 64'h0);
    chk("x0_wen",   64'(rf_we),    64'h0);
    chk("x0_data",  rf_data,       64'hFF);
    tick();
    chk("x0_count", 64'(wr_count), 64'd6);

    // ---- hold: pointer now 2, so req2 is granted first ----
    set_req(0, 1'b1, 5'd1, 64'h101);
    set_req(1, 1'b1, 5'd2, 64'h202);
    set_req(2, 1'b1, 5'd3, 64'h303);
    #1;
    chk("hd_ready_pre", 64'(req_ready), 64'b100);
    tick();
    hold = 1'b1;
    #1;
    chk("hd_ready_a", 64'(req_ready), 64'h0);
    chk("hd_wen_a",   64'(rf_we),     64'h1);
    chk("hd_addr_a",  64'(rf_addr),   64'd3);
    tick();
    chk("hd_ready_b", 64'(req_ready), 64'h0);
    chk("hd_wen_b",   64'(rf_we),     64'h0);
    chk("hd_count",   64'(wr_count),  64'd7);
    tick();
    chk("hd_ready_c", 64'(req_ready), 64'h0);
    chk("hd_wen_c",   64'(rf_we),     64'h0);
    hold = 1'b0;
    #1;
    chk("hd_resume", 64'(req_ready), 64'b001);
    tick();
    req_valid = '0;
    chk("hd_resume_addr", 64'(rf_addr), 64'd1);
    chk("hd_resume_data", rf_data,      64'h101);

    // ---- move pointer to 2 via a lone req1 write ----
    set_req(1, 1'b1, 5'd4, 64'h44);
    #1;
    chk("cl_ready_r1", 64'(req_ready), 64'b010);
    tick();
    set_req(1, 1'b0, 5'd0, 64'h0);

    // ---- same-register collision: req0 and req2 to x7 ----
    set_req(0, 1'b1, 5'd7, 64'h11);
    set_req(2, 1'b1, 5'd7, 64'h22);
    #1;
    chk("cl_ready_first", 64'(req_ready), 64'b100);
    tick();
    set_req(2, 1'b0, 5'd0, 64'h0);
    chk("cl_data_first", rf_data, 64'h22);
    #1;
    chk("cl_ready_second", 64'(req_ready), 64'b001);
    tick();
    set_req(0, 1'b0, 5'd0, 64'h0);
    chk("cl_data_second", rf_data, 64'h11);
    tick();
    chk("cl_x7_final", rf_model[7],    64'h11);
    chk("cl_x4",       rf_model[4],    64'h44);
    chk("cl_count",    64'(wr_count),  64'd11);

`ifdef RF_WB_FWD_EN
    // ---- forwarding: write to x9 in flight ----
    set_req(0, 1'b1, 5'd9, 64'h99);
    tick();
    set_req(0, 1'b0, 5'd0, 64'h0);
    rd_addr_1 = 5'd9;
    rd_addr_2 = 5'd0;
    #1;
    chk("fw_hit1", 64'(fwd_hit_1), 64'h1);
    chk("fw_hit2", 64'(fwd_hit_2), 64'h0);
    // x0 write in flight never hits, even with matching read address
    set_req(1, 1'b1, 5'd0, 64'h55);
    tick();
    set_req(1, 1'b0, 5'd0, 64'h0);
    rd_addr_1 = 5'd0;
    #1;
    chk("fw_x0_hit1", 64'(fwd_hit_1), 64'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
